// File: rtl/fb_port_arbiter_if.sv
// Frame-buffer arbiter bus: pixel write stream, scan-engine read port and single-port RAM port.
// slave is the arbiter's view; master is the surrounding system's view.
interface fb_port_arbiter_if #(
   parameter int unsigned BITS_PER_PIXEL = 16,
   parameter int unsigned ADDR_BITS      = 11
);
   logic                      wr_pixel_valid;
   logic [BITS_PER_PIXEL-1:0] wr_pixel_data;
   logic                      wr_frame_start;
   logic                      rd_req;
   logic [ADDR_BITS-1:0]      rd_addr;
   logic                      rd_ack;
   logic                      rd_valid;
   logic [BITS_PER_PIXEL-1:0] rd_data;
   logic [ADDR_BITS-1:0]      mem_addr;
   logic                      mem_we;
   logic [BITS_PER_PIXEL-1:0] mem_wdata;
   logic [BITS_PER_PIXEL-1:0] mem_rdata;
   logic                      frame_done;
   logic                      overflow;

   modport slave (
      input  wr_pixel_valid, wr_pixel_data, wr_frame_start, rd_req, rd_addr, mem_rdata,
      output rd_ack, rd_valid, rd_data, mem_addr, mem_we, mem_wdata, frame_done, overflow
   );

   modport master (
      output wr_pixel_valid, wr_pixel_data, wr_frame_start, rd_req, rd_addr, mem_rdata,
      input  rd_ack, rd_valid, rd_data, mem_addr, mem_we, mem_wdata, frame_done, overflow
   );
endinterface

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares the single-port frame-buffer RAM between the buffered SPI pixel
// write stream and the HUB75 scan engine's reads. Reads win unless the write FIFO is full.
module fb_port_arbiter #(
   parameter int unsigned BITS_PER_PIXEL   = 16,
   parameter int unsigned ADDR_BITS        = 11,
   parameter int unsigned PIXELS_PER_FRAME = 2048,
   parameter int unsigned FIFO_DEPTH       = 4
) (
   input logic             clk,
   input logic             reset,
   fb_port_arbiter_if.slave bus
);
   localparam int unsigned PtrBits = $clog2(FIFO_DEPTH);
   localparam int unsigned CntBits = PtrBits + 1;
   localparam logic [CntBits-1:0]   FullCount = CntBits'(FIFO_DEPTH);
   localparam logic [ADDR_BITS-1:0] LastAddr  = ADDR_BITS'(PIXELS_PER_FRAME - 1);

   logic [BITS_PER_PIXEL-1:0] fifo_q [FIFO_DEPTH];
   logic [PtrBits-1:0]        rd_ptr_q, wr_ptr_q;
   logic [CntBits-1:0]        count_q;
   logic [ADDR_BITS-1:0]      wr_addr_q;

   logic [ADDR_BITS-1:0]      mem_addr_q;
   logic                      mem_we_q;
   logic [BITS_PER_PIXEL-1:0] mem_wdata_q;
   logic                      rd_pend_q;
   logic                      rd_valid_q;
   logic                      frame_done_q;
   logic                      overflow_q;

   logic                      fifo_full;
   logic                      fifo_empty;
   logic                      rd_grant;
   logic                      wr_grant;
   logic                      push;
   logic                      store;
   logic [PtrBits-1:0]        store_idx;

   // Grant decision and FIFO push qualification for the current cycle.
   always_comb begin
      fifo_full  = (count_q == FullCount);
      fifo_empty = (count_q == '0);
      // A frame start blocks writes, so a full FIFO cannot stall a read that cycle.
      rd_grant   = bus.rd_req && (bus.wr_frame_start || !fifo_full);
      wr_grant   = !bus.wr_frame_start && (fifo_full || (!bus.rd_req && !fifo_empty));
      push       = bus.wr_pixel_valid && (!fifo_full || wr_grant);
      // On a frame start the flushed FIFO always has room; the pixel lands in slot 0.
      store      = bus.wr_pixel_valid && (bus.wr_frame_start || push);
      store_idx  = bus.wr_frame_start ? '0 : wr_ptr_q;
   end

   // FIFO storage; contents need no reset since the count qualifies them.
   always_ff @(posedge clk) begin
      if (store) begin
         fifo_q[store_idx] <= bus.wr_pixel_data;
      end
   end

   // FIFO pointers, occupancy, write address and sticky overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         wr_addr_q  <= '0;
         overflow_q <= 1'b0;
      end else if (bus.wr_frame_start) begin
         rd_ptr_q  <= '0;
         wr_ptr_q  <= PtrBits'(bus.wr_pixel_valid);
         count_q   <= CntBits'(bus.wr_pixel_valid);
         wr_addr_q <= '0;
      end else begin
         if (wr_grant) begin
            rd_ptr_q  <= rd_ptr_q + PtrBits'(1);
            wr_addr_q <= (wr_addr_q == LastAddr) ? '0 : wr_addr_q + ADDR_BITS'(1);
         end
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PtrBits'(1);
         end
         count_q <= count_q + CntBits'(push) - CntBits'(wr_grant);
         if (bus.wr_pixel_valid && !push) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Registered RAM port, read-valid pipeline and end-of-frame pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_addr_q   <= '0;
         mem_we_q     <= 1'b0;
         mem_wdata_q  <= '0;
         rd_pend_q    <= 1'b0;
         rd_valid_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         // RAM has one cycle of read latency, so valid trails the address by one cycle.
         rd_pend_q    <= rd_grant;
         rd_valid_q   <= rd_pend_q;
         mem_we_q     <= wr_grant;
         frame_done_q <= wr_grant && (wr_addr_q == LastAddr);
         if (rd_grant) begin
            mem_addr_q <= bus.rd_addr;
         end else if (wr_grant) begin
            mem_addr_q  <= wr_addr_q;
            mem_wdata_q <= fifo_q[rd_ptr_q];
         end
      end
   end

   assign bus.rd_ack     = rd_grant;
   assign bus.rd_valid   = rd_valid_q;
   assign bus.rd_data    = bus.mem_rdata;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.frame_done = frame_done_q;
   assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: queue-based model of the arbiter checked every cycle, plus
// hand-computed expectations for each directed scenario.
module tb_fb_port_arbiter;
   localparam int unsigned BPP   = 16;
   localparam int unsigned AB    = 11;
   localparam int unsigned PPF   = 2048;
   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fb_port_arbiter_if #(.BITS_PER_PIXEL(BPP), .ADDR_BITS(AB)) bus ();

   fb_port_arbiter #(
      .BITS_PER_PIXEL  (BPP),
      .ADDR_BITS       (AB),
      .PIXELS_PER_FRAME(PPF),
      .FIFO_DEPTH      (DEPTH)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // RAM contents seen by reads: fixed pattern, 0xABCD at address 5.
   function automatic logic [15:0] rom(input logic [AB-1:0] a);
      logic [15:0] v;
      v = {5'h0, a} ^ 16'h5A5A;
      if (a == 11'h005) v = 16'hABCD;
      return v;
   endfunction

   // One-cycle synchronous read RAM.
   always @(posedge clk) bus.mem_rdata <= rom(bus.mem_addr);

   // ---------------- model ----------------
   logic [15:0]   mq[$];
   int            m_wr_addr;
   logic          e_we, e_fd, e_ov, e_rv, m_pend;
   logic [AB-1:0] e_addr, m_pend_addr;
   logic [15:0]   e_wdata, e_rdata;
   int            wla[$];
   logic [15:0]   wld[$];
   logic [15:0]   mrd[$];
   int            m_fd_count;
   bit            started = 0;
   int            cnum = 0;
   int            m_g;

   // 0 idle, 1 read, 2 write, in the documented priority order.
   function automatic int grant();
      bit full;
      full = (mq.size() == DEPTH);
      if (!bus.wr_frame_start && full) return 2;
      if (bus.rd_req) return 1;
      if (!bus.wr_frame_start && mq.size() != 0) return 2;
      return 0;
   endfunction

   always @(posedge clk) begin
      cnum++;
      if (reset) begin
         mq.delete();
         m_wr_addr = 0;
         e_we = 0; e_addr = '0; e_wdata = '0; e_fd = 0; e_ov = 0; e_rv = 0; m_pend = 0;
         e_rdata = '0; m_pend_addr = '0;
         started = 1;
      end else begin
         m_g = grant();
         e_rv = m_pend;
         if (m_pend) begin
            e_rdata = rom(m_pend_addr);
            mrd.push_back(e_rdata);
         end
         m_pend = (m_g == 1);
         m_pend_addr = bus.rd_addr;
         e_we = (m_g == 2);
         e_fd = 0;
         if (m_g == 1) e_addr = bus.rd_addr;
         if (m_g == 2) begin
            e_wdata = mq.pop_front();
            e_addr = AB'(m_wr_addr);
            wla.push_back(m_wr_addr);
            wld.push_back(e_wdata);
            if (m_wr_addr == PPF - 1) begin
               e_fd = 1;
               m_fd_count++;
            end
            m_wr_addr = (m_wr_addr + 1) % PPF;
         end
         if (bus.wr_frame_start) begin
            mq.delete();
            m_wr_addr = 0;
            if (bus.wr_pixel_valid) mq.push_back(bus.wr_pixel_data);
         end else if (bus.wr_pixel_valid) begin
            if (mq.size() < DEPTH) mq.push_back(bus.wr_pixel_data);
            else e_ov = 1;
         end
      end
   end

   // ---------------- compare + DUT observation ----------------
   bit            ack_neg = 0;
   int            t0 = 0;
   int            stall_q[$];
   int            dwa[$];
   logic [15:0]   dwd[$];
   logic [15:0]   drd[$];
   int            dfd = 0;
   int            dfd_addr = 0;

   always @(negedge clk) begin
      if (started) begin
         chk("rd_ack", bus.rd_ack, grant() == 1);
         chk("mem_we", bus.mem_we, e_we);
         chk("mem_addr", bus.mem_addr, e_addr);
         chk("mem_wdata", bus.mem_wdata, e_wdata);
         chk("rd_valid", bus.rd_valid, e_rv);
         if (e_rv) chk("rd_data", bus.rd_data, e_rdata);
         chk("frame_done", bus.frame_done, e_fd);
         chk("overflow", bus.overflow, e_ov);
         if (bus.mem_we === 1'b1) begin
            dwa.push_back(int'(bus.mem_addr));
            dwd.push_back(bus.mem_wdata);
         end
         if (bus.rd_valid === 1'b1) drd.push_back(bus.rd_data);
         if (bus.frame_done === 1'b1) begin
            dfd++;
            dfd_addr = int'(bus.mem_addr);
         end
         if (bus.rd_req && !bus.rd_ack) stall_q.push_back(cnum - t0);
      end
      ack_neg = (grant() == 1);
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
      bus.wr_pixel_valid = 0;
      bus.wr_frame_start = 0;
   endtask

   task automatic push(input logic [15:0] d);
      bus.wr_pixel_valid = 1;
      bus.wr_pixel_data  = d;
      cyc();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic read_once(input logic [AB-1:0] a);
      bit done;
      done = 0;
      bus.rd_req  = 1;
      bus.rd_addr = a;
      for (int i = 0; i < 20 && !done; i++) begin
         cyc();
         if (ack_neg) done = 1;
      end
      bus.rd_req = 0;
      chk("read_timeout", done, 1);
   endtask

   task automatic clear_logs();
      dwa.delete(); dwd.delete(); drd.delete(); wla.delete(); wld.delete(); mrd.delete();
      stall_q.delete();
      dfd = 0;
      m_fd_count = 0;
   endtask

   logic [15:0] t1d [3];

   initial begin
      reset = 1;
      bus.wr_pixel_valid = 0;
      bus.wr_pixel_data  = '0;
      bus.wr_frame_start = 0;
      bus.rd_req         = 0;
      bus.rd_addr        = '0;
      m_fd_count         = 0;
      t1d = '{16'h1111, 16'h2222, 16'h3333};

      // Reset state.
      idle(2);
      reset = 0;
      chk("reset mem_we", bus.mem_we, 0);
      chk("reset rd_valid", bus.rd_valid, 0);
      chk("reset overflow", bus.overflow, 0);
      chk("reset frame_done", bus.frame_done, 0);
      chk("reset mem_addr", bus.mem_addr, 0);

      // Three pixels, no reads: written to 0,1,2.
      clear_logs();
      push(16'h1111); push(16'h2222); push(16'h3333);
      idle(4);
      chk("t1 dut writes", dwa.size(), 3);
      chk("t1 model writes", wla.size(), 3);
      for (int i = 0; i < 3; i++) begin
         if (i < dwa.size()) begin
            chk("t1 dut addr", dwa[i], i);
            chk("t1 dut data", dwd[i], t1d[i]);
         end
         if (i < wla.size()) begin
            chk("t1 model addr", wla[i], i);
            chk("t1 model data", wld[i], t1d[i]);
         end
      end

      // Single read of address 5.
      clear_logs();
      read_once(11'h005);
      idle(3);
      chk("t2 dut reads", drd.size(), 1);
      if (drd.size() > 0) chk("t2 dut rd_data", drd[0], 16'hABCD);
      chk("t2 model reads", mrd.size(), 1);
      if (mrd.size() > 0) chk("t2 model rd_data", mrd[0], 16'hABCD);

      // Continuous reads while 4 pixels arrive: exactly one forced write at cycle 4.
      clear_logs();
      bus.rd_req = 1; bus.rd_addr = 11'h010;
      t0 = cnum;
      for (int i = 0; i < 4; i++) push(16'h4000 + 16'(i));
      idle(2);
      bus.rd_req = 0;
      idle(5);
      chk("t3 stall count", stall_q.size(), 1);
      if (stall_q.size() > 0) chk("t3 stall cycle", stall_q[0], 4);
      chk("t3 writes", dwa.size(), 4);
      chk("t3 overflow", bus.overflow, 0);

      // Continuous reads with 6 pushes: forced writes at 4,5,6, all pixels kept.
      clear_logs();
      bus.rd_req = 1; bus.rd_addr = 11'h020;
      t0 = cnum;
      for (int i = 0; i < 6; i++) push(16'h6000 + 16'(i));
      idle(2);
      bus.rd_req = 0;
      idle(6);
      chk("t4 stall count", stall_q.size(), 3);
      for (int i = 0; i < 3; i++) if (i < stall_q.size()) chk("t4 stall cycle", stall_q[i], 4 + i);
      chk("t4 writes", dwa.size(), 6);
      if (dwd.size() == 6) chk("t4 last data", dwd[5], 16'h6005);
      chk("t4 overflow", bus.overflow, 0);

      // Full frame plus one pixel, starting with a frame start.
      clear_logs();
      bus.wr_frame_start = 1;
      for (int i = 0; i <= PPF; i++) push(16'(i));
      idle(4);
      chk("t5 writes", dwa.size(), PPF + 1);
      chk("t5 dut frame_done", dfd, 1);
      chk("t5 frame_done addr", dfd_addr, PPF - 1);
      chk("t5 model frame_done", m_fd_count, 1);
      if (wla.size() == PPF + 1) begin
         chk("t5 model last addr", wla[PPF-1], PPF - 1);
         chk("t5 model wrap addr", wla[PPF], 0);
         chk("t5 model wrap data", wld[PPF], 16'h0800);
      end
      if (dwa.size() == PPF + 1) chk("t5 dut wrap addr", dwa[PPF], 0);

      // Frame start discards buffered pixels; the new pixel goes to address 0.
      clear_logs();
      bus.rd_req = 1; bus.rd_addr = 11'h030;
      push(16'hAAAA); push(16'hBBBB);
      bus.wr_frame_start = 1;
      push(16'h7777);
      bus.rd_req = 0;
      idle(4);
      chk("t6 dut writes", dwa.size(), 1);
      if (dwa.size() > 0) begin
         chk("t6 dut addr", dwa[0], 0);
         chk("t6 dut data", dwd[0], 16'h7777);
      end
      chk("t6 model writes", wla.size(), 1);
      if (wld.size() > 0) chk("t6 model data", wld[0], 16'h7777);
      chk("t6 frame_done", dfd, 0);

      // Reset right after a read grant suppresses its rd_valid.
      clear_logs();
      bus.rd_req = 1; bus.rd_addr = 11'h009;
      cyc();
      chk("t7 granted", ack_neg, 1);
      bus.rd_req = 0;
      reset = 1;
      cyc();
      reset = 0;
      idle(4);
      chk("t7 rd_valid count", drd.size(), 0);
      chk("t7 overflow", bus.overflow, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
